uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte sources, e.g. the echo path (req 0) and a status/message generator (req 1).
- Round-robin arbitration with packet lock. Sequences the transmitter's start/busy handshake and enforces an optional inter-frame gap.
- Sits between the requesters and the UART TX shifter. Same 100 MHz clk domain; the shifter runs at 9600 baud, 10417 clk/bit.

Parameters:
- DATA_WIDTH, 8, byte width per requester.
- BUSY_TIMEOUT, 8, clk cycles allowed after tx_start for tx_busy to rise before flagging an error.
- GAP_CYCLES, 0, idle clk cycles inserted after tx_busy falls before the next grant; 0 means no gap.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester byte available.
- req_data  in  2*DATA_WIDTH  packed bytes; [7:0] = req 0, [15:8] = req 1.
- req_last  in  2  byte is the last of a packet; releases the lock.
- req_ready  out  2  one-hot accept strobe, combinational; a byte transfers on valid&ready.
- tx_data  out  DATA_WIDTH  registered byte to the transmitter.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter shifting a frame.
- grant  out  2  one-hot owner of the current or most recent transfer, registered.
- locked  out  1  mid-packet lock active.
- active  out  1  high whenever the FSM is not in IDLE.
- err_timeout  out  1  sticky flag: tx_busy never rose; cleared only by reset.

Behaviour:
- Reset (sampled on the clk edge) puts everything in a known state:
  - state = IDLE; tx_start = 0; tx_data = 0x00; grant = 2'b00.
  - locked = 0; err_timeout = 0; active = 0; req_ready = 0.
  - last_grant pointer = req 1, so req 0 wins the first tie.
  - Reset mid-frame abandons the transfer immediately; the transmitter is reset by its own logic.
- FSM states: IDLE, START, WAIT_HI, WAIT_LO, GAP.
- IDLE, candidate selection:
  - A candidate must have req_valid = 1 and tx_busy = 0.
  - If locked, only the current owner is a candidate; the other requester is ignored even if valid.
  - If not locked and both are valid, the winner is the requester not equal to last_grant (round-robin).
  - If only one is valid, it wins.
- IDLE, on a winner i:
  - req_ready[i] = 1 in that same cycle; the byte transfers.
  - tx_data <= req_data byte i; grant <= onehot(i); last_grant <= i.
  - locked <= ~req_last[i].
  - Next state is START.
  - If there is no candidate, req_ready = 0 and the FSM stays in IDLE.
- START: tx_start = 1 for exactly one cycle, then WAIT_HI.
  - Latency: accept at cycle T gives tx_start high at T+1.
- WAIT_HI:
  - Wait for tx_busy = 1, then go to WAIT_LO.
  - A counter runs from 0. If it reaches BUSY_TIMEOUT with no tx_busy: err_timeout <= 1, locked <= 0, go to GAP (or IDLE if GAP_CYCLES = 0).
- WAIT_LO: wait for tx_busy = 0, then go to GAP, or straight to IDLE if GAP_CYCLES = 0.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- req_ready is 0 in every state except IDLE. tx_data holds its value until the next accept.
- Packet lock:
  - Set on accepting a byte with last = 0.
  - Cleared on accepting a byte with last = 1.
  - While locked, an owner with valid = 0 stalls the arbiter in IDLE indefinitely. This is intended: packets are never interleaved.
- Simultaneous events:
  - reset overrides everything.
  - A tx_busy rise in the same cycle as a timeout expiry counts as success; err_timeout is not set.
  - A requester dropping valid in the same cycle it would be selected is not accepted.
- Counter widths are sized by $clog2 of the respective parameter plus 1.

Test Plan:
- Single byte:
  - Stimulus: req 0 valid with 0x55, last = 1.
  - Response: req_ready = 2'b01 for 1 cycle; tx_start high at T+1; tx_data = 0x55; TXD frame 0x55 at 104170 ns/bit after the shifter; grant = 01; locked = 0.
- Tie, round-robin:
  - Stimulus: both valid, req 0 = 0xA1, req 1 = 0xB2, all last = 1, held continuously.
  - Response: transmit order 0xA1, 0xB2, 0xA1, 0xB2; grant alternates 01, 10.
- Packet lock:
  - Stimulus: req 1 sends 0x10 (last 0), 0x11 (last 0), 0x12 (last 1), while req 0 holds 0x7D valid.
  - Response: 0x10, 0x11, 0x12 sent back-to-back; locked = 1 until the accept of 0x12; then 0x7D goes out.
- Timeout:
  - Stimulus: BUSY_TIMEOUT = 8, transmitter model holds tx_busy = 0.
  - Response: err_timeout rises 8 cycles after tx_start and stays high; the FSM returns to IDLE and serves the next request.
- Gap and reset:
  - Stimulus: GAP_CYCLES = 20, two bytes queued.
  - Response: second tx_start comes ≥21 cycles after tx_busy falls.
  - Stimulus: assert reset during WAIT_LO.
  - Response: next cycle tx_start = 0, grant = 00, locked = 0, active = 0, err_timeout = 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX shifter between two byte sources
// with round-robin arbitration, packet lock, busy timeout and frame gap.
//
// Ports:
//   clk, reset        100 MHz clock, synchronous active-high reset
//   req_valid/_data/_last  two requesters; [7:0] is req 0, [15:8] req 1
//   req_ready         one-hot accept strobe, combinational
//   tx_data/tx_start  registered byte and one-cycle start to the shifter
//   tx_busy           shifter is sending a frame
//   grant             one-hot owner of the current/most recent transfer
//   locked, active    mid-packet lock, FSM not idle
//   err_timeout       sticky: tx_busy never answered a tx_start
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 8,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  input  logic [1:0]              req_last,
  output logic [1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [1:0]              grant,
  output logic                    locked,
  output logic                    active,
  output logic                    err_timeout
);

  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO,
    GAP
  } state_t;

  localparam state_t DONE_ST = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t        state;
  state_t        state_nx;
  logic          last_grant;
  logic [1:0]    cand;
  logic          win;
  logic          accept;
  logic          t_expire;
  logic [TW-1:0] t_cnt;
  logic [GW-1:0] g_cnt;

  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    cand      = 2'b00;
    win       = 1'b0;
    accept    = 1'b0;
    t_expire  = 1'b0;
    tx_start  = (state == START);
    active    = (state != IDLE);
    unique case (state)
      IDLE: begin
        // while locked only the owner (grant) may be picked
        cand = req_valid & {2{~tx_busy}}
             & (locked ? grant : 2'b11);
        if (cand == 2'b11) win = ~last_grant;
        else               win = cand[1];
        if ((|cand) && !reset) begin
          accept    = 1'b1;
          req_ready = win ? 2'b10 : 2'b01;
          state_nx  = START;
        end
      end
      START: state_nx = WAIT_HI;
      WAIT_HI: begin
        // a busy rise on the expiry cycle wins
        if (tx_busy) begin
          state_nx = WAIT_LO;
        end else if (t_cnt == T_LAST) begin
          t_expire = 1'b1;
          state_nx = DONE_ST;
        end
      end
      WAIT_LO: if (!tx_busy) state_nx = DONE_ST;
      GAP: if (g_cnt == G_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data     <= '0;
      grant       <= 2'b00;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      last_grant  <= 1'b1;
      t_cnt       <= '0;
      g_cnt       <= '0;
    end else begin
      if (accept) begin
        tx_data    <= win ? req_data[2*DATA_WIDTH-1:DATA_WIDTH]
                          : req_data[DATA_WIDTH-1:0];
        grant      <= win ? 2'b10 : 2'b01;
        last_grant <= win;
        locked     <= ~req_last[win];
      end
      if (t_expire) begin
        err_timeout <= 1'b1;
        locked      <= 1'b0;
      end
      // counts cycles since the tx_start pulse
      if (accept)
        t_cnt <= '0;
      else if (state == START || state == WAIT_HI)
        t_cnt <= t_cnt + 1'b1;
      if (state == GAP) g_cnt <= g_cnt + 1'b1;
      else              g_cnt <= '0;
    end
  end

endmodule
